// File: rtl/alarm_sequencer.sv
// Alarm episode sequencer: decides when the tune plays, on which song, and handles
// snooze, stop and the auto-off timeout. Every output is taken directly from a register.
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3,
    parameter int CNT_W       = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1hz,
    input  logic       i_armed,
    input  logic       i_match,
    input  logic       i_snooze_btn,
    input  logic       i_stop_btn,
    input  logic [1:0] i_song_cfg,
    output logic       o_alarm,
    output logic [1:0] o_sel,
    output logic [1:0] o_state,
    output logic [3:0] o_snooze_cnt,
    output logic       o_timed_out
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RING   = 2'b01,
        S_SNOOZE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
    localparam logic [3:0]       SNZ_MAX     = 4'(MAX_SNOOZES);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_sec_cnt, w_sec_nx;
    logic [3:0]       r_snz_cnt, w_snz_nx;
    logic [1:0]       r_sel, w_sel_nx;
    logic             r_alarm, r_timed_out, w_to_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_sec_cnt   <= '0;
            r_snz_cnt   <= '0;
            r_sel       <= 2'b00;
            r_alarm     <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sec_cnt   <= w_sec_nx;
            r_snz_cnt   <= w_snz_nx;
            r_sel       <= w_sel_nx;
            r_alarm     <= (w_state_nx == S_RING);
            r_timed_out <= w_to_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sec_nx   = r_sec_cnt;
        w_snz_nx   = r_snz_cnt;
        w_sel_nx   = r_sel;
        w_to_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_match && i_armed) begin
                    w_state_nx = S_RING;
                    w_sel_nx   = i_song_cfg;
                    w_sec_nx   = '0;
                    w_snz_nx   = '0;
                end
            end
            S_RING: begin
                // A snooze refused at the limit falls through so the tick still counts.
                if (i_stop_btn || !i_armed) begin
                    w_state_nx = S_IDLE;
                end else if (i_snooze_btn && (r_snz_cnt < SNZ_MAX)) begin
                    w_state_nx = S_SNOOZE;
                    w_snz_nx   = r_snz_cnt + 4'd1;
                    w_sec_nx   = '0;
                end else if (i_tick_1hz) begin
                    if (r_sec_cnt == RING_LAST) begin
                        w_state_nx = S_IDLE;
                        w_to_nx    = 1'b1;
                    end else begin
                        w_sec_nx = r_sec_cnt + 1'b1;
                    end
                end
            end
            S_SNOOZE: begin
                if (i_stop_btn || !i_armed) begin
                    w_state_nx = S_IDLE;
                end else if (i_tick_1hz) begin
                    if (r_sec_cnt == SNOOZE_LAST) begin
                        w_state_nx = S_RING;
                        w_sec_nx   = '0;
                    end else begin
                        w_sec_nx = r_sec_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign o_alarm      = r_alarm;
    assign o_sel        = r_sel;
    assign o_state      = r_state;
    assign o_snooze_cnt = r_snz_cnt;
    assign o_timed_out  = r_timed_out;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed episodes plus random traffic against a
// countdown-based reference model of the alarm episode.
module tb_alarm_sequencer;
    localparam int RING_SECS   = 4;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZES = 2;

    logic       i_clk = 1'b0;
    logic       i_rst, i_tick_1hz, i_armed, i_match, i_snooze_btn, i_stop_btn;
    logic [1:0] i_song_cfg;
    logic       o_alarm, o_timed_out;
    logic [1:0] o_sel, o_state;
    logic [3:0] o_snooze_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 idle, 1 ring, 2 snooze; m_left = ticks remaining in phase
    int m_mode = 0, m_left = 0, m_snz = 0, m_sel = 0, m_to = 0;

    alarm_sequencer #(
        .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZES(MAX_SNOOZES), .CNT_W(9)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick_1hz(i_tick_1hz), .i_armed(i_armed),
        .i_match(i_match), .i_snooze_btn(i_snooze_btn), .i_stop_btn(i_stop_btn),
        .i_song_cfg(i_song_cfg), .o_alarm(o_alarm), .o_sel(o_sel), .o_state(o_state),
        .o_snooze_cnt(o_snooze_cnt), .o_timed_out(o_timed_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst, tick, armed, match, snz, stop, input int cfg);
        if (rst) begin
            m_mode = 0; m_left = 0; m_snz = 0; m_sel = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_mode == 0) begin
            if (match && armed) begin
                m_mode = 1; m_sel = cfg; m_left = RING_SECS; m_snz = 0;
            end
        end else if (stop || !armed) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (snz && m_snz < MAX_SNOOZES) begin
                m_mode = 2; m_snz++; m_left = SNOOZE_SECS;
            end else if (tick) begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_to = 1; end
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin m_mode = 1; m_left = RING_SECS; end
        end
    endtask

    task automatic step(input bit rst, tick, armed, match, snz, stop, input int cfg);
        i_rst = rst; i_tick_1hz = tick; i_armed = armed; i_match = match;
        i_snooze_btn = snz; i_stop_btn = stop; i_song_cfg = 2'(cfg);
        @(posedge i_clk);
        #1;
        model(rst, tick, armed, match, snz, stop, cfg);
        chk("state", int'(o_state), m_mode);
        chk("alarm", int'(o_alarm), (m_mode == 1) ? 1 : 0);
        chk("sel", int'(o_sel), m_sel);
        chk("snooze_cnt", int'(o_snooze_cnt), m_snz);
        chk("timed_out", int'(o_timed_out), m_to);
    endtask

    // bare tick in whichever state, armed, with configured song cfg
    task automatic tick(input int cfg);
        step(0, 1, 1, 0, 0, 0, cfg);
        step(0, 0, 1, 0, 0, 0, cfg);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 3);
        chk("reset_state", int'(o_state), 0);
        chk("reset_sel", int'(o_sel), 0);

        // 1: match -> ring one cycle later, auto-off after exactly 4 ticks
        step(0, 0, 1, 1, 0, 0, 1);
        chk("t1_alarm", int'(o_alarm), 1);
        chk("t1_sel", int'(o_sel), 1);
        for (int i = 0; i < 3; i++) tick(1);
        chk("t1_still_ring", int'(o_state), 1);
        step(0, 1, 1, 0, 0, 0, 1);
        chk("t1_timed_out", int'(o_timed_out), 1);
        chk("t1_idle", int'(o_state), 0);
        step(0, 0, 1, 0, 0, 0, 1);
        chk("t1_to_pulse", int'(o_timed_out), 0);

        // 2: snooze cycles and the limit
        step(0, 0, 1, 1, 0, 0, 2);
        step(0, 0, 1, 0, 1, 0, 2);
        chk("t2_snooze", int'(o_state), 2);
        for (int i = 0; i < 3; i++) tick(2);
        chk("t2_back_ring", int'(o_state), 1);
        step(0, 0, 1, 0, 1, 0, 2);
        chk("t2_cnt2", int'(o_snooze_cnt), 2);
        for (int i = 0; i < 3; i++) tick(2);
        step(0, 0, 1, 0, 1, 0, 2);
        chk("t2_third_ignored", int'(o_state), 1);

        // 3: stop beats snooze; snooze beats a terminal tick
        step(0, 0, 1, 0, 1, 1, 2);
        chk("t3_stop", int'(o_state), 0);
        chk("t3_cnt_kept", int'(o_snooze_cnt), 2);
        step(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0);
        step(0, 1, 1, 0, 1, 0, 0);
        chk("t3_snz_over_tick", int'(o_state), 2);
        chk("t3_no_timeout", int'(o_timed_out), 0);

        // 4: disarmed match ignored; disarm in snooze ends episode
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("t4_disarmed", int'(o_state), 0);
        step(0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t4_disarm_snz", int'(o_state), 0);

        // 5: mid-episode match and song change do nothing
        step(0, 0, 1, 1, 0, 0, 1);
        tick(1);
        step(0, 0, 1, 1, 0, 0, 2);
        chk("t5_sel", int'(o_sel), 1);
        for (int i = 0; i < 2; i++) tick(2);
        step(0, 1, 1, 0, 0, 0, 2);
        chk("t5_no_restart", int'(o_timed_out), 1);

        // 6: reset in snooze with a tick
        step(0, 0, 1, 1, 0, 0, 3);
        step(0, 0, 1, 0, 1, 0, 3);
        step(1, 1, 1, 0, 0, 0, 3);
        chk("t6_state", int'(o_state), 0);
        chk("t6_cnt", int'(o_snooze_cnt), 0);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) == 0),
                 int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
